mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit words in the backing store (power of two, 4..4096).
REQ-002 Parameter: WAIT, 2, wait states inserted before response (0..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: IF  input  1  instruction-fetch strobe from controller; one-cycle pulse, read request.
REQ-006 Port: MEM  input  1  data-access strobe from controller; one-cycle pulse, read or write per we.
REQ-007 Port: we  input  1  write enable, sampled only with MEM; ignored with IF.
REQ-008 Port: addr  input  32  byte address, sampled with the accepted strobe.
REQ-009 Port: wdata  input  32  write data, sampled with MEM when we=1.
REQ-010 Port: rdata  output  32  read data, valid in the ready cycle only.
REQ-011 Port: ready  output  1  one-cycle pulse: access complete.
REQ-012 Port: busy  output  1  high from the cycle after acceptance until the ready cycle inclusive.
REQ-013 Port: err  output  1  one-cycle pulse on a rejected or failed request.

Function
REQ-014 FSM states: IDLE, WAITING, RESP; one state register, no other states.
REQ-015 IDLE: exactly one of IF/MEM high -> latch addr, we (MEM only), wdata; go WAITING if WAIT>0, else RESP.
REQ-016 WAITING: down-counter loaded with WAIT-1 on acceptance; decrement each cycle; at 0 go RESP.
REQ-017 RESP: ready=1, busy=1 for one cycle; return to IDLE next cycle.
REQ-018 Latency: strobe accepted in cycle N -> ready in cycle N+WAIT+1 exactly.
REQ-019 Read: rdata = store[addr[log2(DEPTH)+1:2]] in the ready cycle; rdata = 0 in all other cycles.
REQ-020 Write: store updated at the ready-cycle edge; rdata = 0 in that ready cycle.
REQ-021 Misaligned (addr[1:0] != 0) in IDLE: no access, stay IDLE, err=1 next cycle, no ready.
REQ-022 Out of range (addr[31:2] >= DEPTH) in IDLE: no access, stay IDLE, err=1 next cycle, no ready.
REQ-023 IF and MEM both high in IDLE: request rejected, store untouched, err=1 next cycle.
REQ-024 Any strobe while state != IDLE: ignored (no latch, no queue), err=1 next cycle; current access unaffected.
REQ-025 Strobe in the RESP cycle counts as busy: ignored with err; back-to-back accepts need one IDLE cycle.
REQ-026 err and ready never high in the same cycle except per REQ-024/025 (err for the ignored strobe may coincide with ready for the current access).
REQ-027 Store contents are not initialised; reads of unwritten words are don't-care for verification.

Reset
REQ-028 reset=1 at an edge: state IDLE, counter 0, ready=0, busy=0, err=0, rdata=0 next cycle.
REQ-029 reset mid-access (WAITING or RESP): access aborted, pending write discarded, no ready emitted.
REQ-030 Strobes in a reset cycle are ignored; store contents unchanged by reset.
REQ-031 First access accepted on the first edge with reset=0.

Verification
REQ-032 WAIT=2: MEM we=1 addr=0x10 wdata=0xDEADBEEF at cycle N -> ready at N+3; then IF addr=0x10 -> ready 3 cycles later, rdata=0xDEADBEEF.
REQ-033 WAIT=0: IF addr=0x10 after the above write -> ready next cycle, busy high in that cycle only, rdata=0xDEADBEEF.
REQ-034 IF addr=0x12 -> err pulse one cycle later, no ready, busy stays 0; IF and MEM together addr=0x10 -> err, store unchanged.
REQ-035 DEPTH=256: MEM read addr=0x400 -> err, no ready; addr=0x3FC -> ready after WAIT+1, busy high throughout.
REQ-036 MEM write in flight, second IF at N+1 -> err at N+2, original ready at N+WAIT+1, second request never answered.
REQ-037 MEM we=1 addr=0x20 wdata=0x12345678, reset=1 in WAITING -> no ready; later read of 0x20 returns prior value (pre-written 0x0).

Source files
------------

// File: rtl/mem_resp.sv
// Word-addressed backing store with a fixed wait-state response FSM.
// One request in flight; malformed or overlapping strobes are answered with an err pulse.
module mem_resp #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF,
    input  logic        MEM,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     store_q [DEPTH];

    logic strobe, bad_req;

    assign strobe  = IF | MEM;
    assign bad_req = (IF & MEM) | (addr[1:0] != 2'b00) | ({2'b00, addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = addr[AW+1:2];
                        we_d    = MEM & we;
                        wdata_d = wdata;
                        cnt_d   = WAIT_M1;
                        state_d = (WAIT > 0) ? WAITING : RESP;
                    end
                end
            end
            WAITING: begin
                err_d = strobe;
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                // A strobe landing on the ready cycle is still refused.
                err_d   = strobe;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Store is never cleared; reset only blocks the pending commit.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && we_q) store_q[idx_q] <= wdata_q;
    end

    assign ready = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign err   = err_q;
    assign rdata = (ready && !we_q) ? store_q[idx_q] : 32'd0;
endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: WAIT=2 and WAIT=0 instances checked against a transaction-level model.
module tb_mem_resp;
    logic        clk = 1'b0;
    logic        reset;
    logic        if0, mem0, if1, mem1;
    logic        we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, busy0, busy1, err0, err1;

    int n_chk  = 0;
    int n_fail = 0;

    int          lat [2] = '{2, 0};
    logic [31:0] model [2][256];
    bit          known [2][256];

    always #5 clk = ~clk;

    mem_resp #(.DEPTH(256), .WAIT(2)) u0 (
        .clk(clk), .reset(reset), .IF(if0), .MEM(mem0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));
    mem_resp #(.DEPTH(256), .WAIT(0)) u1 (
        .clk(clk), .reset(reset), .IF(if1), .MEM(mem1), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs(input int sel, input string tag, input logic r, input logic b, input logic e);
        chk({tag, " ready"}, (sel != 0) ? 32'(ready1) : 32'(ready0), 32'(r));
        chk({tag, " busy"},  (sel != 0) ? 32'(busy1)  : 32'(busy0),  32'(b));
        chk({tag, " err"},   (sel != 0) ? 32'(err1)   : 32'(err0),   32'(e));
    endtask

    function automatic logic [31:0] rd(input int sel);
        return (sel != 0) ? rdata1 : rdata0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: strobe, expected err or ready after lat+1 cycles, then idle.
    task automatic access(input int sel, input bit i_f, input bit i_m, input bit w,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        bit bad, wr;
        int idx, n;
        bad = (i_f && i_m) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        wr  = i_m && w;
        idx = int'(a[9:2]);
        n   = lat[sel] + 1;
        @(negedge clk);
        addr = a; wdata = d; we = w;
        if (sel == 0) begin if0 = i_f; mem0 = i_m; end
        else          begin if1 = i_f; mem1 = i_m; end
        tick();
        if0 = 0; mem0 = 0; if1 = 0; mem1 = 0;
        if (bad) begin
            outs(sel, {tag, " rej"}, 1'b0, 1'b0, 1'b1);
            tick();
            outs(sel, {tag, " rej+1"}, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            outs(sel, $sformatf("%s c%0d", tag, k), (k == n), 1'b1, 1'b0);
            if (k < n) chk({tag, " rdata idle"}, rd(sel), 32'd0);
            else if (wr) chk({tag, " rdata wr"}, rd(sel), 32'd0);
            else if (known[sel][idx]) chk({tag, " rdata"}, rd(sel), model[sel][idx]);
            if (k < n) tick();
        end
        if (wr) begin
            model[sel][idx] = d;
            known[sel][idx] = 1'b1;
        end
        tick();
        outs(sel, {tag, " after"}, 1'b0, 1'b0, 1'b0);
        chk({tag, " rdata after"}, rd(sel), 32'd0);
    endtask

    initial begin
        reset = 1; if0 = 0; mem0 = 0; if1 = 0; mem1 = 0; we = 0; addr = 0; wdata = 0;
        tick();
        tick();
        outs(0, "reset0", 1'b0, 1'b0, 1'b0);
        outs(1, "reset1", 1'b0, 1'b0, 1'b0);
        chk("reset0 rdata", rdata0, 32'd0);
        chk("reset1 rdata", rdata1, 32'd0);
        reset = 0;

        // Write-then-read on both latencies.
        access(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, "w2 wr");
        access(0, 1, 0, 0, 32'h10, 32'h0, "w2 rd");
        access(1, 0, 1, 1, 32'h10, 32'hDEADBEEF, "w0 wr");
        access(1, 1, 0, 0, 32'h10, 32'h0, "w0 rd");

        // Rejections: misaligned, dual strobe, out of range, then last legal word.
        access(0, 1, 0, 0, 32'h12, 32'h0, "misal");
        access(0, 1, 1, 1, 32'h10, 32'h0BAD0BAD, "dual");
        access(0, 1, 0, 0, 32'h10, 32'h0, "dual chk");
        access(0, 0, 1, 0, 32'h400, 32'h0, "oor");
        access(0, 0, 1, 1, 32'h3FC, 32'hA5A5F00F, "top wr");
        access(0, 0, 1, 0, 32'h3FC, 32'h0, "top rd");

        // Strobes while busy and on the ready cycle are refused with err.
        @(negedge clk);
        mem0 = 1; we = 1; addr = 32'h30; wdata = 32'hCAFE0030;
        tick();
        mem0 = 0; if0 = 1; we = 0; addr = 32'h40;
        outs(0, "ovl N+1", 1'b0, 1'b1, 1'b0);
        tick();
        if0 = 0;
        outs(0, "ovl N+2", 1'b0, 1'b1, 1'b1);
        tick();
        if0 = 1; addr = 32'h30;
        outs(0, "ovl N+3", 1'b1, 1'b1, 1'b0);
        chk("ovl rdata", rdata0, 32'd0);
        tick();
        if0 = 0;
        outs(0, "ovl N+4", 1'b0, 1'b0, 1'b1);
        model[0][12] = 32'hCAFE0030; known[0][12] = 1'b1;
        tick();
        outs(0, "ovl N+5", 1'b0, 1'b0, 1'b0);
        access(0, 1, 0, 0, 32'h30, 32'h0, "ovl rd");

        // Reset during WAITING drops the pending write.
        access(0, 0, 1, 1, 32'h20, 32'h0, "pre wr");
        @(negedge clk);
        mem0 = 1; we = 1; addr = 32'h20; wdata = 32'h12345678;
        tick();
        mem0 = 0;
        reset = 1;
        tick();
        reset = 0;
        outs(0, "rst abort", 1'b0, 1'b0, 1'b0);
        chk("rst abort rdata", rdata0, 32'd0);
        tick();
        tick();
        outs(0, "rst quiet", 1'b0, 1'b0, 1'b0);
        access(0, 1, 0, 0, 32'h20, 32'h0, "rst rd");

        // Randomized mix of legal and malformed requests.
        for (int i = 0; i < 60; i++) begin
            int sel, r;
            logic [31:0] a, d;
            bit isif, w;
            sel  = int'($urandom % 2);
            r    = int'($urandom % 10);
            d    = $urandom;
            isif = ($urandom % 2) == 0;
            w    = ($urandom % 2) == 0;
            a    = 32'(($urandom % 16) * 4);
            case (r)
                6: access(sel, isif, !isif, w, a | 32'(1 + $urandom % 3), d, "rnd misal");
                7: access(sel, isif, !isif, w, 32'h400 + 32'(($urandom % 1000) * 4), d, "rnd oor");
                8: access(sel, 1, 1, w, a, d, "rnd dual");
                9: access(sel, isif, !isif, w, 32'(($urandom % 256) * 4), d, "rnd far");
                default: access(sel, isif, !isif, w, a, d, "rnd");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
